// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 4x4 systolic matrix-multiply array (y = a*b).
// A 16-word B stream is loaded into a held weight bank. Four A rows are buffered
// and then issued to the array on four enabled cycles. Result rows are collected
// onto a ready/valid stream, and the array is stalled through arr_en under
// backpressure.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, reload_b        job start pulse; reload_b=1 loads a new B first
//   busy, done, err        job in flight, completion pulse, sticky drain timeout
//   s_b_*                  B element stream (row-major b00..b33)
//   s_a_*                  A row stream (lane k at [k*WIDTH +: WIDTH])
//   m_y_*                  result row stream, m_y_last on the 4th row
//   arr_*                  array interface (enable, clear, a/b operands, results)
module systolic_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DRAIN_MAX = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  reload_b,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [WIDTH-1:0]      s_b_data,
  input  logic                  s_b_valid,
  output logic                  s_b_ready,
  input  logic [4*WIDTH-1:0]    s_a_data,
  input  logic                  s_a_valid,
  output logic                  s_a_ready,
  output logic [4*WIDTH-1:0]    m_y_data,
  output logic                  m_y_valid,
  input  logic                  m_y_ready,
  output logic                  m_y_last,
  output logic                  arr_en,
  output logic                  arr_clr,
  output logic [4*WIDTH-1:0]    arr_a,
  output logic                  arr_in_valid,
  output logic [16*WIDTH-1:0]   arr_b,
  input  logic [4*WIDTH-1:0]    arr_y,
  input  logic                  arr_out_valid
);

  localparam int unsigned DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {StIdle, StLoadB, StLoadA, StIssue, StDrain} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     b_bank_q [16];
  logic [4*WIDTH-1:0]   a_buf_q  [4];
  logic [3:0]           b_cnt_q, b_cnt_d;
  logic                 b_loaded_q, b_loaded_d;
  logic [1:0]           a_cnt_q, a_cnt_d;     // A load index, reused as issue index
  logic [1:0]           row_cnt_q, row_cnt_d;
  logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 clr_q, clr_d;
  logic [4*WIDTH-1:0]   y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic                 y_last_q, y_last_d;

  logic b_we, a_we, capture, y_hs;

  // The array is frozen whenever a held result cannot leave, in every state.
  assign arr_en    = !(y_valid_q && !m_y_ready);
  assign s_b_ready = (state_q == StLoadB);
  assign s_a_ready = (state_q == StLoadA);
  assign b_we      = s_b_ready && s_b_valid;
  assign a_we      = s_a_ready && s_a_valid;
  // Results arriving while idle or loading are stale and dropped.
  assign capture   = arr_out_valid && arr_en && (state_q == StIssue || state_q == StDrain);
  assign y_hs      = y_valid_q && m_y_ready;

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;
  assign arr_clr      = clr_q;
  assign arr_in_valid = (state_q == StIssue);
  assign arr_a        = (state_q == StIssue) ? a_buf_q[a_cnt_q] : '0;
  assign m_y_data     = y_q;
  assign m_y_valid    = y_valid_q;
  assign m_y_last     = y_valid_q && y_last_q;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      arr_b[i*WIDTH +: WIDTH] = b_bank_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    b_cnt_d     = b_cnt_q;
    b_loaded_d  = b_loaded_q;
    a_cnt_d     = a_cnt_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    clr_d       = 1'b0;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    y_last_d    = y_last_q;

    if (capture) begin
      y_d       = arr_y;
      y_valid_d = 1'b1;
      y_last_d  = (row_cnt_q == 2'd3);
      row_cnt_d = row_cnt_q + 2'd1;
    end else if (y_hs) begin
      y_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr_d       = 1'b1;
          err_d       = 1'b0;
          row_cnt_d   = '0;
          drain_cnt_d = '0;
          a_cnt_d     = '0;
          b_cnt_d     = '0;
          state_d     = (reload_b || !b_loaded_q) ? StLoadB : StLoadA;
        end
      end
      StLoadB: begin
        if (b_we) begin
          b_cnt_d = b_cnt_q + 4'd1;
          if (b_cnt_q == 4'd15) begin
            b_loaded_d = 1'b1;
            state_d    = StLoadA;
          end
        end
      end
      StLoadA: begin
        if (a_we) begin
          a_cnt_d = a_cnt_q + 2'd1;
          if (a_cnt_q == 2'd3) state_d = StIssue;
        end
      end
      StIssue: begin
        if (arr_en) begin
          a_cnt_d = a_cnt_q + 2'd1;
          if (a_cnt_q == 2'd3) state_d = StDrain;
        end
      end
      StDrain: begin
        if (y_hs && y_last_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (capture) begin
          drain_cnt_d = '0;
        end else if (arr_en) begin
          drain_cnt_d = drain_cnt_q + DW'(1);
          if (drain_cnt_q + DW'(1) == DW'(DRAIN_MAX)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      b_cnt_q     <= '0;
      b_loaded_q  <= 1'b0;
      a_cnt_q     <= '0;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      clr_q       <= 1'b0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      y_last_q    <= 1'b0;
      for (int i = 0; i < 16; i++) b_bank_q[i] <= '0;
      for (int i = 0; i < 4; i++)  a_buf_q[i]  <= '0;
    end else begin
      state_q     <= state_d;
      b_cnt_q     <= b_cnt_d;
      b_loaded_q  <= b_loaded_d;
      a_cnt_q     <= a_cnt_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      clr_q       <= clr_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      y_last_q    <= y_last_d;
      if (b_we) b_bank_q[b_cnt_q] <= s_b_data;
      if (a_we) a_buf_q[a_cnt_q]  <= s_a_data;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl with a behavioural 3-stage array model.
module tb_systolic_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, reload_b, busy, done, err;
  logic [W-1:0]    s_b_data;
  logic            s_b_valid, s_b_ready;
  logic [4*W-1:0]  s_a_data;
  logic            s_a_valid, s_a_ready;
  logic [4*W-1:0]  m_y_data;
  logic            m_y_valid, m_y_ready, m_y_last;
  logic            arr_en, arr_clr, arr_in_valid, arr_out_valid;
  logic [4*W-1:0]  arr_a, arr_y;
  logic [16*W-1:0] arr_b;

  systolic_ctrl #(.WIDTH(W), .DRAIN_MAX(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload_b(reload_b),
    .busy(busy), .done(done), .err(err),
    .s_b_data(s_b_data), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_a_data(s_a_data), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .m_y_data(m_y_data), .m_y_valid(m_y_valid), .m_y_ready(m_y_ready), .m_y_last(m_y_last),
    .arr_en(arr_en), .arr_clr(arr_clr), .arr_a(arr_a), .arr_in_valid(arr_in_valid),
    .arr_b(arr_b), .arr_y(arr_y), .arr_out_valid(arr_out_valid)
  );

  // ---------------- array model: y_c = sum_k a_k * b_kc, latency 3 ----------------
  bit             dead = 1'b0;
  logic [4*W-1:0] p_y [3];
  logic           p_v [3];

  function automatic logic [4*W-1:0] mm(input logic [4*W-1:0] a, input logic [16*W-1:0] b);
    logic [4*W-1:0] r;
    for (int c = 0; c < 4; c++) begin
      logic signed [W-1:0]   acc;
      logic signed [2*W-1:0] prod;
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        prod = $signed(a[k*W +: W]) * $signed(b[(4*k+c)*W +: W]);
        acc  = acc + prod[W-1:0];
      end
      r[c*W +: W] = acc;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || arr_clr) begin
      for (int i = 0; i < 3; i++) begin p_v[i] <= 1'b0; p_y[i] <= '0; end
    end else if (arr_en) begin
      p_v[0] <= arr_in_valid;
      p_y[0] <= mm(arr_a, arr_b);
      p_v[1] <= p_v[0]; p_y[1] <= p_y[0];
      p_v[2] <= p_v[1]; p_y[2] <= p_y[1];
    end
  end
  assign arr_y         = p_y[2];
  assign arr_out_valid = p_v[2] && !dead;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] row4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // ---------------- monitor (samples on negedge) ----------------
  logic [4*W-1:0] res_q [$];
  logic           lst_q [$];
  int inval_cnt, rises, done_cnt, en_bad, drain_cyc, clr_cnt, stall_cnt;
  bit sb_seen, prev_iv;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (m_y_valid && m_y_ready) begin res_q.push_back(m_y_data); lst_q.push_back(m_y_last); end
      if (arr_in_valid && arr_en) inval_cnt++;
      if (arr_in_valid && !prev_iv) rises++;
      prev_iv = arr_in_valid;
      if (busy && arr_en && !arr_in_valid && inval_cnt == 4) drain_cyc++;
      if (s_b_ready) sb_seen = 1'b1;
      if (done) done_cnt++;
      if (arr_clr) clr_cnt++;
      if (!arr_en) stall_cnt++;
      if (arr_en !== !(m_y_valid && !m_y_ready)) en_bad++;
    end
  end

  // ---------------- m_y_ready driver ----------------
  bit bp_en = 1'b0;
  int hold_n;
  initial begin
    m_y_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!bp_en) m_y_ready = 1'b1;
      else if (hold_n < 5) begin
        if (res_q.size() == 1 && m_y_valid) begin m_y_ready = 1'b0; hold_n++; end
        else m_y_ready = 1'b1;
      end else m_y_ready = ~m_y_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clear_mon();
    res_q.delete(); lst_q.delete();
    inval_cnt = 0; rises = 0; done_cnt = 0; en_bad = 0; drain_cyc = 0;
    clr_cnt = 0; stall_cnt = 0; sb_seen = 0; hold_n = 0;
  endtask

  task automatic do_start(input bit rl);
    start = 1'b1; reload_b = rl; tick(); start = 1'b0; reload_b = 1'b0;
  endtask

  task automatic send_b();
    for (int i = 0; i < 16; i++) begin
      int n = 0;
      s_b_valid = 1'b1; s_b_data = W'(i + 1);
      while (!s_b_ready && n < 50) begin tick(); n++; end
      if (n == 50) check_eq("b_handshake_timeout", n, 0);
      tick();
    end
    s_b_valid = 1'b0;
  endtask

  task automatic send_a(input logic [4*W-1:0] row, input int gap);
    int n = 0;
    s_a_valid = 1'b1; s_a_data = row;
    while (!s_a_ready && n < 50) begin tick(); n++; end
    if (n == 50) check_eq("a_handshake_timeout", n, 0);
    tick();
    s_a_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  logic err_at_start;

  task automatic run_job(input bit rl, input bit sendb, input bit ident, input int gap, input bit bp);
    int n = 0;
    clear_mon();
    bp_en = bp;
    do_start(rl);
    err_at_start = err;
    if (sendb) send_b();
    for (int r = 0; r < 4; r++) begin
      logic [63:0] idr;
      idr = '0;
      idr[r*W +: W] = W'(1);
      send_a(ident ? idr : row4(4*r+1, 4*r+2, 4*r+3, 4*r+4), gap);
    end
    while (busy && n < 400) begin tick(); n++; end
    if (n == 400) check_eq("job_busy_timeout", n, 0);
    bp_en = 1'b0;
    tick(); tick();
  endtask

  task automatic check_rows(input string tag, input bit ident);
    logic [63:0] exp [4];
    logic [3:0]  lb;
    for (int r = 0; r < 4; r++) exp[r] = row4(4*r+1, 4*r+2, 4*r+3, 4*r+4);
    if (!ident) begin
      exp[0] = row4(90, 100, 110, 120);
      exp[1] = row4(202, 228, 254, 280);
      exp[2] = row4(314, 356, 398, 440);
      exp[3] = row4(426, 484, 542, 600);
    end
    check_eq($sformatf("%s_nrows", tag), res_q.size(), 4);
    lb = '0;
    for (int r = 0; r < 4; r++) begin
      check_eq($sformatf("%s_row%0d", tag, r), (r < res_q.size()) ? res_q[r] : 'x, exp[r]);
      if (r < lst_q.size()) lb[r] = lst_q[r];
    end
    check_eq($sformatf("%s_last", tag), lb, 4'b1000);
    check_eq($sformatf("%s_done", tag), done_cnt, 1);
    check_eq($sformatf("%s_inval", tag), inval_cnt, 4);
    check_eq($sformatf("%s_inval_runs", tag), rises, 1);
    check_eq($sformatf("%s_en_rule", tag), en_bad, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    start = 0; reload_b = 0; s_b_data = '0; s_b_valid = 0; s_a_data = '0; s_a_valid = 0;
    clear_mon();
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_b_ready", s_b_ready, 0);
    check_eq("rst_a_ready", s_a_ready, 0);
    check_eq("rst_y_valid", m_y_valid, 0);
    check_eq("rst_in_valid", arr_in_valid, 0);
    check_eq("rst_arr_b", arr_b, '0);
    tick(); tick(); rst_n = 1'b1; tick();
    check_eq("rst_arr_en", arr_en, 1);

    // First start with reload_b=0 must still load B.
    run_job(0, 1, 0, 0, 0);
    check_eq("s5_b_loaded", sb_seen, 1);
    check_rows("s5", 0);

    run_job(1, 1, 0, 0, 0);
    check_eq("s1_clr_pulses", clr_cnt, 1);
    check_rows("s1", 0);

    run_job(0, 0, 1, 0, 0);
    check_eq("s2_no_b_ready", sb_seen, 0);
    check_rows("s2", 1);

    run_job(1, 1, 0, 0, 1);
    check_eq("s3_stalled", stall_cnt >= 5, 1);
    check_rows("s3", 0);

    run_job(0, 0, 0, 3, 0);
    check_rows("s4", 0);

    // Drain timeout: the array never produces a result.
    dead = 1'b1;
    run_job(0, 0, 0, 0, 0);
    check_eq("s6_err", err, 1);
    check_eq("s6_busy", busy, 0);
    check_eq("s6_no_done", done_cnt, 0);
    check_eq("s6_drain_cycles", drain_cyc, 32);
    check_eq("s6_no_rows", res_q.size(), 0);
    dead = 1'b0;

    run_job(0, 0, 0, 0, 0);
    check_eq("s6_err_cleared", err_at_start, 0);
    check_rows("s6b", 0);

    // Reset in the middle of DRAIN.
    dead = 1'b1;
    clear_mon();
    do_start(0);
    for (int r = 0; r < 4; r++) send_a(row4(4*r+1, 4*r+2, 4*r+3, 4*r+4), 0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("s6r_in_drain", busy, 1);
    rst_n = 1'b0; #1;
    check_eq("s6r_busy", busy, 0);
    check_eq("s6r_err", err, 0);
    check_eq("s6r_y_valid", m_y_valid, 0);
    check_eq("s6r_arr_b", arr_b, '0);
    check_eq("s6r_a_ready", s_a_ready, 0);
    tick(); rst_n = 1'b1; dead = 1'b0; tick();
    run_job(0, 1, 0, 0, 0);
    check_eq("s6r_b_reloaded", sb_seen, 1);
    check_rows("s6r", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
